// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational ALU among N requesters.
// One operation in flight at a time: IDLE grants, EXEC samples the ALU, RESP holds the response.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP    = 4,
  parameter int unsigned N     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*OP-1:0]      req_op,
  input  logic [N*WIDTH-1:0]   req_a,
  input  logic [N*WIDTH-1:0]   req_b,
  input  logic [N*5-1:0]       req_shamt,
  output logic [WIDTH-1:0]     alu_rs1,
  output logic [WIDTH-1:0]     alu_rs2,
  output logic [OP-1:0]        alu_op,
  output logic [4:0]           alu_shamt,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_branch,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_branch,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned CW  = IDW + 1;
  localparam int unsigned SHW = 5;
  localparam logic [OP-1:0]  OP_FIRST_ILLEGAL = OP'(14);
  localparam logic [IDW-1:0] LAST_RESET       = IDW'(N - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [OP-1:0]    op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             err_q, err_d;

  logic [OP-1:0]    op_arr    [N];
  logic [WIDTH-1:0] a_arr     [N];
  logic [WIDTH-1:0] b_arr     [N];
  logic [SHW-1:0]   shamt_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign op_arr[i]    = req_op[i*OP +: OP];
    assign a_arr[i]     = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i]     = req_b[i*WIDTH +: WIDTH];
    assign shamt_arr[i] = req_shamt[i*SHW +: SHW];
  end

  // Round-robin search starting one past the last winner, wrapping at N
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [CW-1:0]  cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = CW'(last_q) + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  logic exec_err_c;
  assign exec_err_c = (op_q >= OP_FIRST_ILLEGAL);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    shamt_d   = shamt_q;
    res_d     = res_q;
    br_d      = br_q;
    err_d     = err_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          id_d    = grant_idx;
          last_d  = grant_idx;
          op_d    = op_arr[grant_idx];
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          shamt_d = shamt_arr[grant_idx];
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Unsupported opcodes squash whatever the ALU produced
        res_d   = exec_err_c ? '0 : alu_result;
        br_d    = !exec_err_c && alu_branch;
        err_d   = exec_err_c;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RESET;
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shamt_q <= shamt_d;
      res_q   <= res_d;
      br_q    <= br_d;
      err_q   <= err_d;
    end
  end

  assign alu_rs1    = a_q;
  assign alu_rs2    = b_q;
  assign alu_op     = op_q;
  assign alu_shamt  = shamt_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_branch = br_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width SHALL be WIDTH bits.
REQ-002 Parameter OP, default 4, opcode width SHALL be OP bits, encoding identical to the core ALU (0 add … 13 slt).
REQ-003 Parameter N, default 3, number of requesters SHALL be N (2..8).
REQ-004 Port list SHALL be as follows, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  requester i has an operation pending.
- req_ready  out  N  one-hot grant/accept; handshake when req_valid[i]&req_ready[i].
- req_op  in  N*OP  per-requester opcode, slice i = [i*OP +: OP].
- req_a  in  N*WIDTH  per-requester rs1 operand.
- req_b  in  N*WIDTH  per-requester rs2 operand.
- req_shamt  in  N*5  per-requester shift amount.
- alu_rs1  out  WIDTH  to ALU rs1.
- alu_rs2  out  WIDTH  to ALU rs2.
- alu_op  out  OP  to ALU op.
- alu_shamt  out  5  to ALU shifter_size.
- alu_result  in  WIDTH  from ALU result.
- alu_branch  in  1  from ALU branch_control.
- rsp_valid  out  1  response held valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  clog2(N)  index of requester owning the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_branch  out  1  captured branch decision.
- rsp_err  out  1  opcode was 14 or 15 (unsupported).
- busy  out  1  high in EXEC or RESP.

Function
REQ-005 FSM SHALL have states IDLE, EXEC, RESP, encoded in a registered state variable.
REQ-006 IDLE: if any req_valid, arbiter SHALL assert exactly one req_ready bit (combinational, same cycle); else req_ready = 0.
REQ-007 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod N, wrapping; last_grant resets to N-1 so requester 0 wins first.
REQ-008 On handshake in IDLE: latch op/a/b/shamt of the granted requester, latch id, update last_grant, go to EXEC.
REQ-009 req_ready SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait, never be dropped or latched.
REQ-010 alu_* outputs SHALL be driven only from the latched operand registers (never directly from req_* inputs) and hold stable for the whole EXEC cycle.
REQ-011 EXEC lasts exactly one cycle: capture alu_result into rsp_result, alu_branch into rsp_branch, set rsp_err = (latched op ≥ 14), go to RESP.
REQ-012 When rsp_err=1, rsp_result SHALL be 0 and rsp_branch 0 regardless of ALU outputs.
REQ-013 RESP: rsp_valid=1; rsp_id/rsp_result/rsp_branch/rsp_err SHALL hold stable until rsp_ready=1; on rsp_valid&rsp_ready go to IDLE.
REQ-014 Latency: handshake at cycle T -> rsp_valid first high at T+2; minimum issue interval 3 cycles.
REQ-015 rsp_valid SHALL be 0 in IDLE and EXEC; busy = (state != IDLE).
REQ-016 If rsp_ready is held high, the RESP->IDLE transition and the next grant SHALL occur on consecutive cycles (no extra bubble beyond IDLE).
REQ-017 A requester that deasserts req_valid before being granted SHALL lose its turn with no side effect.

Reset
REQ-018 While rst=1 at a clock edge: state=IDLE, last_grant=N-1, all operand/response registers=0.
REQ-019 After reset, outputs SHALL be rsp_valid=0, rsp_id=0, rsp_result=0, rsp_branch=0, rsp_err=0, busy=0, req_ready=0 (absent req_valid), alu_*=0.
REQ-020 Reset asserted in EXEC or RESP SHALL abort the operation; no response SHALL be emitted for it.

Verification
REQ-021 Single add: req0 op=0 a=5 b=7, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_result=12, rsp_err=0.
REQ-022 Round-robin: all 3 valid continuously -> grants in order 0,1,2,0; each rsp_id matches.
REQ-023 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready stays 0, then single accept returns to IDLE.
REQ-024 Branch: req1 op=9 (beq) a=b=0x10 -> rsp_branch=1, rsp_result=0; op=10 (bne) same operands -> rsp_branch=0.
REQ-025 Illegal opcode: req2 op=15 -> rsp_err=1, rsp_result=0, rsp_branch=0, FSM returns to IDLE.
REQ-026 Reset mid-EXEC: rst pulsed one cycle during EXEC -> no rsp_valid, next grant goes to requester 0.
